// File: rtl/sio_pkg.sv
// Shared definitions for the serial I/O bus controller: FSM state encoding,
// status register bit positions and command/data select levels.
// No ports; imported by the controller top.
package sio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STAT_RD,
    STAT_CAP,
    DATA_RD,
    DATA_CAP,
    DATA_WR
  } state_e;

  localparam int   STAT_TX_READY_BIT = 0;
  localparam int   STAT_RX_READY_BIT = 1;

  localparam logic CD_CMD  = 1'b1;
  localparam logic CD_DATA = 1'b0;

endpackage

// File: rtl/sio_bus_ctrl_if.sv
// Serial port strobe bus: ce/rd/wr/cd strobes, write data and read data.
// Latency: none, wires only. Backpressure: none, the port is polled via status.
// master = controller (drives strobes/wdata), slave = port (drives rdata).
interface sio_bus_ctrl_if;

  logic       sio_ce;
  logic       sio_rd;
  logic       sio_wr;
  logic       sio_cd;
  logic [7:0] sio_wdata;
  logic [7:0] sio_rdata;

  modport master (
    output sio_ce, sio_rd, sio_wr, sio_cd, sio_wdata,
    input  sio_rdata
  );

  modport slave (
    input  sio_ce, sio_rd, sio_wr, sio_cd, sio_wdata,
    output sio_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**AW entries of W bits.
// Latency: pushed word visible on dout_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; both may act together.
// Ports: clk/rst, push_i/din_i, pop_i, dout_o (0 while empty), full_o, empty_o, level_o.
module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head is forced to zero while empty so the output is defined after reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sio_bus_ctrl.sv
// Autonomous serial port bus master: polls port status, moves RX bytes into a FIFO, feeds TX FIFO bytes out.
// Latency: idle poll 3 cycles; port byte to RX FIFO <= 5 cycles; tx_push to port write 4 cycles best case.
// Backpressure: RX full leaves the byte in the port; tx_push ignored when tx_full, rx_pop ignored when rx_empty.
// Ports: clk/rst; host TX side tx_data/tx_push/tx_full/tx_level; host RX side rx_data/rx_pop/rx_empty;
//        err/err_clr sticky error flags; sio = port strobe bus (master side).
// Build option SIO_CTRL_ERR_EN: enables the sticky push-when-full / pop-when-empty flags, else err = 0.
module sio_bus_ctrl
  import sio_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic [FIFO_AW:0]   tx_level,
  output logic [7:0]         rx_data,
  input  logic               rx_pop,
  output logic               rx_empty,
  output logic [1:0]         err,
  input  logic               err_clr,
  sio_bus_ctrl_if.master     sio
);

  state_e       state_q, state_d;

  logic         ce, rd, wr, cd;
  logic [7:0]   wdata;
  logic         tx_pop_int, rx_push_int;
  logic [7:0]   tx_head;
  logic         tx_empty, rx_full;
  logic [FIFO_AW:0] rx_level_unused;

  sync_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (tx_data),
    .pop_i   (tx_pop_int),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  sync_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push_int),
    .din_i   (sio.sio_rdata),
    .pop_i   (rx_pop),
    .dout_o  (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ce          = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    cd          = 1'b0;
    wdata       = 8'h00;
    tx_pop_int  = 1'b0;
    rx_push_int = 1'b0;
    unique case (state_q)
      IDLE: state_d = STAT_RD;
      STAT_RD: begin
        ce      = 1'b1;
        rd      = 1'b1;
        cd      = CD_CMD;
        state_d = STAT_CAP;
      end
      STAT_CAP: begin
        // The status byte is on sio_rdata this cycle; RX service wins over TX.
        if (sio.sio_rdata[STAT_RX_READY_BIT] && !rx_full)
          state_d = DATA_RD;
        else if (sio.sio_rdata[STAT_TX_READY_BIT] && !tx_empty)
          state_d = DATA_WR;
        else
          state_d = IDLE;
      end
      DATA_RD: begin
        ce      = 1'b1;
        rd      = 1'b1;
        cd      = CD_DATA;
        state_d = DATA_CAP;
      end
      DATA_CAP: begin
        rx_push_int = 1'b1;
        state_d     = IDLE;
      end
      DATA_WR: begin
        ce         = 1'b1;
        wr         = 1'b1;
        cd         = CD_DATA;
        wdata      = tx_head;
        tx_pop_int = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sio.sio_ce    = ce;
  assign sio.sio_rd    = rd;
  assign sio.sio_wr    = wr;
  assign sio.sio_cd    = cd;
  assign sio.sio_wdata = wdata;

`ifdef SIO_CTRL_ERR_EN
  logic [1:0] err_q, err_d;

  // Clear first, then set, so a set event in the clearing cycle survives.
  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    if (tx_push && tx_full)  err_d[0] = 1'b1;
    if (rx_pop  && rx_empty) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 2'b00;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 2'b00;
`endif

endmodule

// File: tb/tb_sio_bus_ctrl.sv
// Bench for sio_bus_ctrl: directed stimulus, port behavioural model, and a
// scoreboard monitor that checks every port write and every host pop.
module tb_sio_bus_ctrl;
  import sio_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_push = 1'b0;
  logic       rx_pop  = 1'b0;
  logic       err_clr = 1'b0;
  logic       tx_full, rx_empty;
  logic [4:0] tx_level;
  logic [7:0] rx_data;
  logic [1:0] err;

  always #5 clk = ~clk;

  sio_bus_ctrl_if sio ();

  sio_bus_ctrl #(.FIFO_AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .tx_level (tx_level),
    .rx_data  (rx_data),
    .rx_pop   (rx_pop),
    .rx_empty (rx_empty),
    .err      (err),
    .err_clr  (err_clr),
    .sio      (sio)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] port_q[$];

  int   data_rd_cnt = 0;
  int   data_wr_cnt = 0;
  int   busy_cnt    = 0;
  logic hold        = 1'b0;
  logic prev_strobe = 1'b0;
  logic [7:0] port_rdata = 8'hEE;

  assign sio.sio_rdata = port_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Port model: read data appears the cycle after the strobe; a write makes
  // the transmitter busy for a few cycles; rx_ready while a byte is queued.
  always @(posedge clk) begin
    logic txr, rxr;
    txr = (busy_cnt == 0) && !hold;
    rxr = (port_q.size() != 0);
    if (sio.sio_ce && sio.sio_rd && sio.sio_cd)
      port_rdata <= {6'b0, rxr, txr};
    else if (sio.sio_ce && sio.sio_rd && !sio.sio_cd)
      port_rdata <= rxr ? port_q.pop_front() : 8'hEE;
    else
      port_rdata <= 8'hEE;
    if (sio.sio_ce && sio.sio_wr && !sio.sio_cd) busy_cnt <= 4;
    else if (busy_cnt != 0)                      busy_cnt <= busy_cnt - 1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    #1;
    chk("rd_wr_exclusive", {31'b0, sio.sio_rd && sio.sio_wr}, 0);
    if (!sio.sio_wr) chk("wdata_idle_zero", {24'b0, sio.sio_wdata}, 0);
    chk("strobe_spacing", {31'b0, prev_strobe && sio.sio_ce}, 0);
    prev_strobe = sio.sio_ce;
    if (sio.sio_ce && sio.sio_wr) begin
      data_wr_cnt++;
      chk("wr_cd_data", {31'b0, sio.sio_cd}, 0);
      chk("wr_port_ready", busy_cnt, 0);
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=0x%0h required=no write", sio.sio_wdata);
      end else begin
        chk("tx_byte", {24'b0, sio.sio_wdata}, {24'b0, exp_tx.pop_front()});
      end
    end
    if (sio.sio_ce && sio.sio_rd && !sio.sio_cd) data_rd_cnt++;
    if (rx_pop && !rx_empty) begin
      if (exp_rx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=0x%0h required=empty", rx_data);
      end else begin
        chk("rx_byte", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    if (!tx_full) exp_tx.push_back(b);
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_tx.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_strobes"}, {28'b0, sio.sio_ce, sio.sio_rd, sio.sio_wr, sio.sio_cd}, 0);
    chk({name, "_wdata"},   {24'b0, sio.sio_wdata}, 0);
    chk({name, "_tx_full"}, {31'b0, tx_full}, 0);
    chk({name, "_tx_level"}, {27'b0, tx_level}, 0);
    chk({name, "_rx_empty"}, {31'b0, rx_empty}, 1);
    chk({name, "_rx_data"}, {24'b0, rx_data}, 0);
    chk({name, "_err"},     {30'b0, err}, 0);
  endtask

  initial begin
    int n, rd0, wr0;

    // Power-on reset
    tick(3);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Reset in the middle of a port write
    push_tx(8'hB1);
    push_tx(8'hB2);
    n = 0;
    while (!sio.sio_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wr_reached", {31'b0, sio.sio_wr}, 1);
    rst = 1'b1;
    @(posedge clk);
    exp_tx.delete();  // B2 is flushed by the reset; B1 already went out
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outputs("midrst");
    end
    rst = 1'b0;

    // TX: two bytes, in order, second only after port ready again
    push_tx(8'hA5);
    chk("tx_level_1", {27'b0, tx_level}, 1);
    push_tx(8'h3C);
    chk("tx_level_2", {27'b0, tx_level}, 2);
    wr0 = data_wr_cnt - 2 + exp_tx.size();
    wait_tx_drain(40, "tx_drain");
    chk("tx_write_count", data_wr_cnt - wr0, 2);
    chk("tx_level_0", {27'b0, tx_level}, 0);

    // RX: one byte from the port
    rd0 = data_rd_cnt;
    exp_rx.push_back(8'h5A);
    port_q.push_back(8'h5A);
    n = 0;
    while (rx_empty && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rx_arrived", {31'b0, rx_empty}, 0);
    chk("rx_head", {24'b0, rx_data}, 32'h5A);
    tick(6);
    chk("rx_one_read", data_rd_cnt - rd0, 1);
    pop_rx();
    chk("rx_empty_after_pop", {31'b0, rx_empty}, 1);

    // Priority: RX and TX both ready in the same status read
    hold = 1'b1;
    tick(4);
    push_tx(8'h77);
    tick(4);
    rd0 = data_rd_cnt;
    wr0 = data_wr_cnt;
    exp_rx.push_back(8'hC3);
    port_q.push_back(8'hC3);
    hold = 1'b0;
    n = 0;
    while (data_rd_cnt == rd0 && data_wr_cnt == wr0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("prio_rd_first", data_rd_cnt - rd0, 1);
    chk("prio_wr_after", data_wr_cnt - wr0, 0);
    wait_tx_drain(20, "prio_tx_drain");
    chk("prio_wr_count", data_wr_cnt - wr0, 1);
    tick(2);
    pop_rx();

    // RX full: 16 queued, 17th stays in the port until a pop
    rd0 = data_rd_cnt;
    for (int i = 0; i < 17; i++) begin
      port_q.push_back(8'h10 + 8'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    n = 0;
    while (data_rd_cnt - rd0 < 16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rxfull_16_read", data_rd_cnt - rd0, 16);
    tick(20);
    chk("rxfull_no_17th", data_rd_cnt - rd0, 16);
    chk("rxfull_port_holds", port_q.size(), 1);
    chk("rxfull_head", {24'b0, rx_data}, 32'h10);
    pop_rx();
    n = 0;
    while (data_rd_cnt - rd0 < 17 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("rxfull_17th_read", data_rd_cnt - rd0, 17);
    tick(3);
    for (int i = 0; i < 16; i++) pop_rx();
    chk("rxfull_drained", exp_rx.size(), 0);
    chk("rxfull_empty", {31'b0, rx_empty}, 1);

    // Error flags
    hold = 1'b1;
    tick(4);
    for (int i = 0; i < 16; i++) push_tx(8'h80 + 8'(i));
    chk("tx_full_set", {31'b0, tx_full}, 1);
    chk("tx_level_16", {27'b0, tx_level}, 16);
    chk("err_before", {30'b0, err}, 0);
    push_tx(8'hEE);
    tick(1);
`ifdef SIO_CTRL_ERR_EN
    chk("err_push_full", {30'b0, err}, 1);
`else
    chk("err_push_full", {30'b0, err}, 0);
`endif
    pop_rx();
    tick(1);
`ifdef SIO_CTRL_ERR_EN
    chk("err_pop_empty", {30'b0, err}, 3);
`else
    chk("err_pop_empty", {30'b0, err}, 0);
`endif
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", {30'b0, err}, 0);
    // Set beats clear in the same cycle
    err_clr = 1'b1;
    push_tx(8'hEF);
    err_clr = 1'b0;
`ifdef SIO_CTRL_ERR_EN
    chk("err_set_wins", {30'b0, err}, 1);
`else
    chk("err_set_wins", {30'b0, err}, 0);
`endif
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared2", {30'b0, err}, 0);
    hold = 1'b0;
    wait_tx_drain(300, "err_tx_drain");
    chk("final_tx_level", {27'b0, tx_level}, 0);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sio_bus_ctrl.md
# sio_bus_ctrl

Autonomous bus master for the serial I/O port. Continuously polls the port's status register over its ce/rd/wr/cd bus, moves received bytes into an RX FIFO and feeds queued bytes from a TX FIFO to the transmitter. The CPU/glue side sees only two FIFOs and never touches the port's command/data protocol. Sits between the system bus decode and the serial port instance.

## Interface
- FIFO_AW, 4, log2 of each FIFO depth (depth 16)
- clk  in  1  system clock; the serial port uses the same clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_push  in  1  enqueue tx_data; ignored when tx_full
- tx_full  out  1  TX FIFO full
- tx_level  out  FIFO_AW+1  TX FIFO occupancy
- rx_data  out  8  RX FIFO head, valid while !rx_empty
- rx_pop  in  1  dequeue RX head; ignored when rx_empty
- rx_empty  out  1  RX FIFO empty
- err  out  2  sticky errors: [0] push-when-full, [1] pop-when-empty (see Configuration)
- err_clr  in  1  clears err
- sio_ce, sio_rd, sio_wr, sio_cd  out  1 each  port strobes; cd=1 command/status, cd=0 data
- sio_wdata  out  8  port write data
- sio_rdata  in  8  port read data; status bit0 = tx_ready, bit1 = rx_ready

## Operation
- FSM states: IDLE, STAT_RD, STAT_CAP, DATA_RD, DATA_CAP, DATA_WR.
- IDLE: all strobes 0; next state STAT_RD unconditionally.
- STAT_RD: ce=1, rd=1, cd=1 for one cycle -> STAT_CAP.
- STAT_CAP: strobes 0; register sio_rdata[1:0]. Decision, RX first:
  - rx_ready=1 and RX FIFO not full -> DATA_RD.
  - else tx_ready=1 and TX FIFO not empty -> DATA_WR.
  - else -> IDLE.
- DATA_RD: ce=1, rd=1, cd=0 for one cycle -> DATA_CAP.
- DATA_CAP: strobes 0; push sio_rdata into RX FIFO -> IDLE.
- DATA_WR: ce=1, wr=1, cd=0, sio_wdata = TX head; pop TX FIFO the same cycle -> IDLE.
- RX full with port rx_ready: the byte stays in the port and the controller keeps polling. Bytes arriving at the port meanwhile are lost by the port; the controller does not flag this.
- Simultaneous host push and internal pop on TX, or internal push and host pop on RX, in one cycle: both take effect; level unchanged.
- sio_wdata = 8'h00 whenever wr=0. sio_rdata is sampled only in STAT_CAP and DATA_CAP; undriven values at other times are ignored.
- rd and wr are never both 1. At most one strobe cycle in any 2 consecutive cycles.

## Timing
- Reset (rst high at a clk edge): state IDLE; all sio_* = 0; FIFOs empty; tx_full=0, tx_level=0, rx_empty=1, rx_data=8'h00, err=0. Reset mid-transfer aborts it. A byte already written to the port still goes out. A byte pending in the port stays there and is read on the first poll after reset.
- Poll loop with nothing to do: 3 cycles (IDLE, STAT_RD, STAT_CAP).
- Port byte to RX FIFO: 5 cycles max after rx_ready is visible in status. rx_empty falls the cycle after DATA_CAP.
- tx_push to port write: 4 cycles best case (IDLE entered with tx_ready=1).
- After DATA_WR, the next status read already returns tx_ready=0, because the port clears the flag on the write edge.
- FIFOs are first-word-fall-through. rx_data updates the cycle after rx_pop.

## Configuration
- SIO_CTRL_ERR_EN defined: err[0] sets on tx_push while tx_full; err[1] sets on rx_pop while rx_empty. Both bits are sticky until err_clr; if err_clr and a set event occur in the same cycle, set wins.
- Not defined: err is constantly 2'b00 and err_clr is ignored. FIFO behaviour is identical in both builds.

## Structure
- Shared package sio_pkg holds:
  - state enum;
  - STAT_TX_READY_BIT=0, STAT_RX_READY_BIT=1;
  - CD_CMD=1'b1, CD_DATA=1'b0.
- Sub-module sync_fifo (parameter AW, width 8, FWFT, full/empty/level outputs), instantiated once for TX and once for RX.

## Test plan
- Reset: rst held 3 cycles during a DATA_WR -> all outputs take their reset values on the next edge; strobes 0; rx_empty=1.
- TX: push 8'hA5, 8'h3C with the port model idle -> two wr cycles with cd=0, sio_wdata A5 then 3C. The second write starts only after the status read returns tx_ready=1.
- RX: model sets rx_ready with data 8'h5A -> exactly one cd=0 read; rx_data=5A; rx_empty falls ≤5 cycles later.
- Priority: rx_ready=1, tx_ready=1, TX FIFO non-empty -> DATA_RD is issued before DATA_WR.
- RX full: 16 bytes queued, a 17th pending in the port -> no data read. After one rx_pop, the 17th byte is read within 5 cycles; order is preserved.
- Errors, SIO_CTRL_ERR_EN defined: push on full -> err[0]=1; pop on empty -> err[1]=1; err_clr -> 2'b00. Without the macro, err stays 2'b00.
